reg_writeback: RTL
==================

// Module: reg_writeback
// PURPOSE
//  Write side of the NPC general-purpose register file. Accepts result writes from EXU
//  (ALU results) and LSU (load data) over valid/ready handshakes. Aligns and extends load
//  data, then buffers writes in a small FIFO. Drains one write per cycle onto the
//  register file's rd/wen/wdata port. Keeps a pending-write scoreboard that IDU uses
//  for RAW hazard stalls.
// PARAMETERS
//  XLEN   32  data width
//  NREG   32  architectural registers; index width = $clog2(NREG)
//  DEPTH  2   writeback FIFO entries (>=1)
// PORTS
//  clk          in   1     clock, all state on posedge
//  rst          in   1     reset, asynchronous, active-high
//  exu_valid    in   1     EXU write request
//  exu_ready    out  1     EXU request accepted this cycle when valid&ready
//  exu_rd       in   5     EXU destination register
//  exu_data     in   XLEN  EXU result
//  lsu_valid    in   1     LSU load-writeback request
//  lsu_ready    out  1     LSU handshake ready
//  lsu_rd       in   5     LSU destination register
//  lsu_rdata    in   XLEN  raw aligned memory word
//  lsu_addr_lo  in   2     load address bits [1:0]
//  lsu_funct3   in   3     load type: LB 000, LH 001, LW 010, LBU 100, LHU 101
//  issue_valid  in   1     IDU issued an instruction that writes issue_rd
//  issue_rd     in   5     destination of issued instruction
//  rf_ready     in   1     register file / difftest able to take a write this cycle
//  rf_wen       out  1     register file write enable
//  rf_rd        out  5     register file write index
//  rf_wdata     out  XLEN  register file write data
//  pending      out  NREG  bit i = write to x[i] in flight
// BEHAVIOUR
//  - Reset (async, any time): FIFO empty, rf_rd=0, rf_wdata=0, pending=0. Requests in
//    flight are discarded, with no partial write. While rst=1, exu_ready=lsu_ready=0
//    and rf_wen=0.
//  - Ready: lsu_ready = !full. exu_ready = !full && !lsu_valid. LSU has fixed priority.
//    There is no same-cycle pop bypass: when the FIFO is full, ready stays 0 even if a
//    pop occurs.
//  - Load extract: byte lane = addr_lo*8. LB/LBU take lsu_rdata[lane+:8] with sign/zero
//    extension. LH/LHU take half lane addr_lo[1]*16 (addr_lo[0] ignored). LW ignores
//    addr_lo. Other funct3 values are treated as LW.
//  - Enqueue on accepted handshake {rd, data}. Requests with rd==0 are accepted and
//    dropped: not enqueued, no write.
//  - Output: rf_wen = !empty && rf_ready, combinational from the registered FIFO head.
//    rf_rd/rf_wdata = head entry. Pop on rf_wen. Latency: handshake at edge N ->
//    rf_wen can be high in cycle N+1 at the earliest. Order is preserved (FIFO).
//  - rf_rd/rf_wdata hold the last head value when the FIFO is empty. They are 0 after
//    reset.
//  - Pointers wrap modulo DEPTH. full/empty come from a count register (0..DEPTH).
//    Simultaneous push and pop when count is 0<c<DEPTH keeps count unchanged.
//  - Scoreboard:
//    - pending[r] is set on issue_valid && issue_rd==r && r!=0.
//    - pending[r] is cleared on rf_wen && rf_rd==r.
//    - Set and clear of the same r in the same cycle -> set wins.
//    - pending[0] is constant 0.
//    - IDU must not issue a second writer to an rd whose pending bit is set.
// STRUCTURE
//  - Shared package npc_wb_pkg: XLEN, REG_IDX_W, load funct3 localparams, wb_entry_t
//    struct {rd, data}.
//  - Sub-module wb_load_align: combinational load lane select plus sign/zero extend.
//  - FIFO, arbitration and scoreboard are implemented inline.
// TESTING
//  1. rst mid-stream with 2 entries queued -> next cycle rf_wen=0 and pending=0;
//     exu_ready=lsu_ready=0 while rst=1.
//  2. exu rd=5 data=0x1234 with rf_ready=1 -> one cycle later rf_wen=1, rf_rd=5,
//     rf_wdata=0x1234.
//  3. lsu_rdata=0x80FF7F01:
//     - LB addr_lo=3 -> 0xFFFFFF80.
//     - LBU addr_lo=2 -> 0x000000FF.
//     - LH addr_lo=2 -> 0xFFFF80FF.
//     - LHU addr_lo=0 -> 0x00007F01.
//  4. exu and lsu valid in the same cycle -> lsu accepted first, exu_ready=0. exu is
//     accepted the next cycle; writes appear in lsu-then-exu order.
//  5. rf_ready=0 for 4 cycles while DEPTH=2:
//     - FIFO fills after 2 handshakes, then both readies drop.
//     - After rf_ready=1, the two writes drain on consecutive cycles in order.
//  6. Scoreboard:
//     - issue rd=7 -> pending[7]=1 until the rf_wen cycle with rd=7.
//     - issue rd=7 in that same cycle -> pending[7] stays 1.
//     - rd=0 request -> no rf_wen, pending unaffected.

Source files
------------

// File: rtl/npc_wb_pkg.sv
// rtl/npc_wb_pkg.sv - shared widths, load funct3 codes and writeback entry type
package npc_wb_pkg;

  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = $clog2(NREG);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_if.sv
// rtl/reg_writeback_if.sv - EXU/LSU/IDU request and register-file write bus
interface reg_writeback_if;
  import npc_wb_pkg::*;

  logic                 exu_valid;
  logic                 exu_ready;
  logic [REG_IDX_W-1:0] exu_rd;
  logic [XLEN-1:0]      exu_data;

  logic                 lsu_valid;
  logic                 lsu_ready;
  logic [REG_IDX_W-1:0] lsu_rd;
  logic [XLEN-1:0]      lsu_rdata;
  logic [1:0]           lsu_addr_lo;
  logic [2:0]           lsu_funct3;

  logic                 issue_valid;
  logic [REG_IDX_W-1:0] issue_rd;

  logic                 rf_ready;
  logic                 rf_wen;
  logic [REG_IDX_W-1:0] rf_rd;
  logic [XLEN-1:0]      rf_wdata;

  logic [NREG-1:0]      pending;

  // Requesters and the register file side
  modport master (
    output exu_valid, exu_rd, exu_data,
    output lsu_valid, lsu_rd, lsu_rdata, lsu_addr_lo, lsu_funct3,
    output issue_valid, issue_rd, rf_ready,
    input  exu_ready, lsu_ready, rf_wen, rf_rd, rf_wdata, pending
  );

  // Writeback block
  modport slave (
    input  exu_valid, exu_rd, exu_data,
    input  lsu_valid, lsu_rd, lsu_rdata, lsu_addr_lo, lsu_funct3,
    input  issue_valid, issue_rd, rf_ready,
    output exu_ready, lsu_ready, rf_wen, rf_rd, rf_wdata, pending
  );

endinterface

// File: rtl/wb_load_align.sv
// rtl/wb_load_align.sv - load byte/half lane select with sign or zero extension
module wb_load_align
  import npc_wb_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the lane from the address, then extend by load type; unknown types act as LW
  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - register-file writeback: arbitration, FIFO, RAW scoreboard
module reg_writeback
  import npc_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic            clk,
  input logic            rst,
  reg_writeback_if.slave wb
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  wb_entry_t        last_q, last_d;
  logic [NREG-1:0]  pending_q, pending_d;

  logic            full, empty;
  logic            lsu_fire, exu_fire;
  logic            push, pop;
  wb_entry_t       push_entry;
  wb_entry_t       head;
  logic [XLEN-1:0] load_data;

  wb_load_align u_align (
    .rdata_i   (wb.lsu_rdata),
    .addr_lo_i (wb.lsu_addr_lo),
    .funct3_i  (wb.lsu_funct3),
    .data_o    (load_data)
  );

  // Handshakes: LSU has fixed priority, no pop bypass when full, all quiet in reset
  always_comb begin
    full         = (count_q == CNT_FULL);
    empty        = (count_q == '0);
    wb.lsu_ready = !rst && !full;
    wb.exu_ready = !rst && !full && !wb.lsu_valid;
    lsu_fire     = wb.lsu_valid && wb.lsu_ready;
    exu_fire     = wb.exu_valid && wb.exu_ready;
    // x0 writes complete the handshake but never reach the FIFO
    push         = (lsu_fire && (wb.lsu_rd != '0)) || (exu_fire && (wb.exu_rd != '0));
    push_entry   = lsu_fire ? '{rd: wb.lsu_rd, data: load_data}
                            : '{rd: wb.exu_rd, data: wb.exu_data};
  end

  // Register-file port shows the FIFO head, or the last written entry once drained
  always_comb begin
    head        = mem_q[rd_ptr_q];
    wb.rf_wen   = !rst && !empty && wb.rf_ready;
    pop         = wb.rf_wen;
    wb.rf_rd    = empty ? last_q.rd : head.rd;
    wb.rf_wdata = empty ? last_q.data : head.data;
    wb.pending  = pending_q;
  end

  // FIFO pointer/count and scoreboard next state; issue set beats writeback clear
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      last_d   = head;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    pending_d = pending_q;
    if (pop) pending_d[head.rd] = 1'b0;
    if (wb.issue_valid) pending_d[wb.issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Control state, cleared asynchronously so in-flight writes are dropped whole
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      last_q    <= '0;
      pending_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      last_q    <= last_d;
      pending_q <= pending_d;
    end
  end

  // Entry storage; validity is tracked by the count, so the payload needs no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule
